board_scan_controller: RTL and testbench

Sequencer for the 8×8 reed-switch sensing matrix on the knight-light board. It drives one row at a time and waits a programmable settle time before sampling the 8 column inputs. Each 64-bit frame is debounced over consecutive identical scans. The stable board layout is then handed to the SPI shifter through a four-phase snapshot handshake, so the shifter never sees a layout that changes mid-transfer.

---
 rtl/board_scan_controller.sv | 196 +++++++++++++++++++
 tb/tb_board_scan_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_scan_controller.sv
// board_scan_controller
// Scans an 8x8 reed-switch matrix one row at a time, debounces whole 64-bit
// frames and hands the stable layout to the SPI shifter through a four-phase
// snapshot handshake.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   scan_en   level; scanning runs while high
//   c[7:0]    column sense lines, active-high, synchronous to clk
//   r[7:0]    row drive, one-hot active-high, all-zero when idle/comparing
//   snap_req  snapshot request from the SPI side (level)
//   snap_ack  snapshot acknowledge (level)
//   layout    frozen snapshot; bit 8*i+j = c[j] sampled while r[i] driven
//   change    one-cycle pulse when the stable layout updates
module board_scan_controller #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_en,
  input  logic [7:0]  c,
  output logic [7:0]  r,
  input  logic        snap_req,
  output logic        snap_ack,
  output logic [63:0] layout,
  output logic        change
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    SAMPLE  = 2'd2,
    COMPARE = 2'd3
  } state_t;

  localparam int            SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
  localparam logic [3:0]    DEB_MAX     = 4'(DEBOUNCE_SCANS);

  state_t        state_r, state_s;
  logic [2:0]    row_r, row_s;
  logic [SW-1:0] settle_r, settle_s;
  logic [63:0]   frame_r, frame_s;
  logic [63:0]   cand_r, cand_s;
  logic [3:0]    match_r, match_s;
  logic [63:0]   stable_r, stable_s;
  logic          change_r, change_s;
  logic [7:0]    r_r, r_s;
  logic          ack_r;
  logic [63:0]   layout_r;

  // State register: scan sequencer, debounce state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      row_r    <= 3'd0;
      settle_r <= {SW{1'b0}};
      frame_r  <= 64'd0;
      cand_r   <= 64'd0;
      match_r  <= 4'd0;
      stable_r <= 64'd0;
      change_r <= 1'b0;
      r_r      <= 8'h00;
    end else begin
      state_r  <= state_s;
      row_r    <= row_s;
      settle_r <= settle_s;
      frame_r  <= frame_s;
      cand_r   <= cand_s;
      match_r  <= match_s;
      stable_r <= stable_s;
      change_r <= change_s;
      r_r      <= r_s;
    end
  end

  // Next-state logic: row sequencing, column sampling and frame debounce.
  always_comb begin
    state_s  = state_r;
    row_s    = row_r;
    settle_s = settle_r;
    frame_s  = frame_r;
    cand_s   = cand_r;
    match_s  = match_r;
    stable_s = stable_r;
    change_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (scan_en) begin
          state_s  = DRIVE;
          row_s    = 3'd0;
          settle_s = {SW{1'b0}};
        end else begin
          state_s  = IDLE;
        end
      end
      DRIVE: begin
        if (!scan_en) begin
          // Abandon the partial frame; the debounce run must start over.
          state_s  = IDLE;
          row_s    = 3'd0;
          settle_s = {SW{1'b0}};
          match_s  = 4'd0;
        end else if (settle_r == SETTLE_LAST) begin
          state_s  = SAMPLE;
          settle_s = {SW{1'b0}};
        end else begin
          settle_s = settle_r + SETTLE_ONE;
        end
      end
      SAMPLE: begin
        if (!scan_en) begin
          state_s  = IDLE;
          row_s    = 3'd0;
          settle_s = {SW{1'b0}};
          match_s  = 4'd0;
        end else begin
          frame_s[{row_r, 3'b000} +: 8] = c;
          if (row_r == 3'd7) begin
            state_s = COMPARE;
          end else begin
            state_s = DRIVE;
            row_s   = row_r + 3'd1;
          end
        end
      end
      COMPARE: begin
        if (frame_r == cand_r) begin
          if (match_r >= DEB_MAX) begin
            match_s = DEB_MAX;
          end else begin
            match_s = match_r + 4'd1;
          end
        end else begin
          cand_s  = frame_r;
          match_s = 4'd1;
        end
        // Decision uses the post-update candidate and count.
        if ((match_s == DEB_MAX) && (cand_s != stable_r)) begin
          stable_s = cand_s;
          change_s = 1'b1;
        end else begin
          stable_s = stable_r;
        end
        row_s    = 3'd0;
        settle_s = {SW{1'b0}};
        if (scan_en) begin
          state_s = DRIVE;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s  = IDLE;
        row_s    = 3'd0;
        settle_s = {SW{1'b0}};
      end
    endcase
  end

  // Output logic: row drive for the upcoming cycle, so r is a clean register.
  always_comb begin
    r_s = 8'h00;
    if ((state_s == DRIVE) || (state_s == SAMPLE)) begin
      r_s = 8'h01 << row_s;
    end else begin
      r_s = 8'h00;
    end
  end

  // Snapshot handshake: capture on request rise, hold while acknowledged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_r    <= 1'b0;
      layout_r <= 64'd0;
    end else if (snap_req && !ack_r) begin
      // stable_r here is the pre-update value if an update lands this edge.
      layout_r <= stable_r;
      ack_r    <= 1'b1;
    end else if (!snap_req && ack_r) begin
      ack_r    <= 1'b0;
    end else begin
      ack_r    <= ack_r;
      layout_r <= layout_r;
    end
  end

  assign r        = r_r;
  assign change   = change_r;
  assign snap_ack = ack_r;
  assign layout   = layout_r;

endmodule

// File: tb/tb_board_scan_controller.sv
// tb_board_scan_controller
// Self-checking bench: a matrix model feeds c from r and the board contents,
// a frame-position reference model predicts r/change/snap_ack/layout every
// cycle, plus directed scenarios for latency, bounce, freeze and enable drop.
module tb_board_scan_controller;

  localparam int S  = 4;
  localparam int D  = 3;
  localparam int RP = S + 1;
  localparam int F  = 8 * RP + 1;
  localparam logic [63:0] PIECE = 64'h0000_0000_0020_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scan_en = 1'b0;
  logic        snap_req = 1'b0;
  logic [7:0]  c;
  logic [7:0]  r;
  logic        snap_ack;
  logic [63:0] layout;
  logic        change;
  logic [63:0] board = 64'd0;

  int total = 0;
  int bad = 0;
  int n_change = 0;

  // Reference model state
  bit          m_active;
  int          m_pos;
  int          m_cnt;
  logic [63:0] m_frame, m_cand, m_stable;
  logic [7:0]  exp_r;
  logic        exp_change, exp_ack;
  logic [63:0] exp_layout;

  board_scan_controller #(.SETTLE_CYCLES(S), .DEBOUNCE_SCANS(D)) dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .c(c), .r(r),
    .snap_req(snap_req), .snap_ack(snap_ack), .layout(layout), .change(change)
  );

  always #5 clk = ~clk;

  // Reed-switch matrix: each driven row connects its closed squares to c.
  always_comb begin
    c = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (r[i]) c = c | board[8*i +: 8];
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_pos = 0; m_cnt = 0;
    m_frame = 64'd0; m_cand = 64'd0; m_stable = 64'd0;
    exp_r = 8'h00; exp_change = 1'b0; exp_ack = 1'b0; exp_layout = 64'd0;
  endtask

  // Predicts the outputs after the next edge from the frame position.
  task automatic model_step(input logic en, input logic req);
    int row;
    exp_change = 1'b0;
    if (req && !exp_ack) begin
      exp_layout = m_stable;
      exp_ack = 1'b1;
    end else if (!req && exp_ack) begin
      exp_ack = 1'b0;
    end
    if (!m_active) begin
      if (en) begin m_active = 1'b1; m_pos = 0; end
    end else if (m_pos < 8 * RP) begin
      if (!en) begin
        m_active = 1'b0;
        m_cnt = 0;
      end else begin
        row = m_pos / RP;
        if (m_pos % RP == S) m_frame[8*row +: 8] = board[8*row +: 8];
        m_pos++;
      end
    end else begin
      if (m_frame == m_cand) begin
        if (m_cnt < D) m_cnt++;
      end else begin
        m_cand = m_frame;
        m_cnt = 1;
      end
      if (m_cnt == D && m_cand != m_stable) begin
        m_stable = m_cand;
        exp_change = 1'b1;
      end
      if (en) m_pos = 0; else m_active = 1'b0;
    end
    if (m_active && m_pos < 8 * RP) exp_r = 8'h01 << (m_pos / RP);
    else exp_r = 8'h00;
  endtask

  // One clock: apply inputs at negedge, predict, then check at next negedge.
  task automatic cycle(input logic en, input logic req);
    scan_en = en;
    snap_req = req;
    model_step(en, req);
    @(posedge clk);
    @(negedge clk);
    check_val("r", {56'd0, r}, {56'd0, exp_r});
    check_val("change", {63'd0, change}, {63'd0, exp_change});
    check_val("snap_ack", {63'd0, snap_ack}, {63'd0, exp_ack});
    check_val("layout", layout, exp_layout);
    if (change) n_change++;
  endtask

  initial begin
    int first_change;
    logic [63:0] pat1, pat2;
    logic [63:0] pats [4];
    logic req;

    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_r", {56'd0, r}, 64'd0);
    check_val("rst_change", {63'd0, change}, 64'd0);
    check_val("rst_ack", {63'd0, snap_ack}, 64'd0);
    check_val("rst_layout", layout, 64'd0);
    reset = 1'b0;

    // Static piece at row 2 / col 5: update at the third frame's COMPARE.
    board = PIECE;
    n_change = 0;
    first_change = -1;
    for (int k = 1; k <= 200; k++) begin
      cycle(1'b1, 1'b0);
      if (change && first_change < 0) first_change = k;
    end
    check_val("static_latency", 64'(first_change), 64'd124);
    check_val("static_pulses", 64'(n_change), 64'd1);
    cycle(1'b1, 1'b1);
    check_val("static_layout", layout, PIECE);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);

    // Bounce every frame: never stable.
    n_change = 0;
    for (int f = 0; f < 10; f++) begin
      board = board ^ PIECE;
      repeat (F) cycle(1'b1, 1'b0);
    end
    check_val("bounce_pulses", 64'(n_change), 64'd0);

    // Two bouncing frames then held clear: exactly one update.
    n_change = 0;
    board = board ^ PIECE; repeat (F) cycle(1'b1, 1'b0);
    board = board ^ PIECE; repeat (F) cycle(1'b1, 1'b0);
    board = board ^ PIECE; repeat (5 * F) cycle(1'b1, 1'b0);
    check_val("settle_pulses", 64'(n_change), 64'd1);

    // Handshake freeze.
    pat1 = {$urandom, $urandom} | 64'h1;
    pat2 = ~pat1;
    board = pat1;
    repeat (5 * F) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    check_val("snapA", layout, pat1);
    board = pat2;
    n_change = 0;
    repeat (5 * F) cycle(1'b1, 1'b1);
    check_val("freeze_pulses", 64'(n_change), 64'd1);
    check_val("freeze_layout", layout, pat1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    check_val("snapB", layout, pat2);

    // Asynchronous reset mid-scan while row 3 is driven.
    for (int k = 0; k < 100 && r !== 8'h08; k++) cycle(1'b1, 1'b1);
    check_val("wait_r08", {56'd0, r}, 64'h08);
    #2 reset = 1'b1;
    #1;
    check_val("arst_r", {56'd0, r}, 64'd0);
    check_val("arst_layout", layout, 64'd0);
    check_val("arst_ack", {63'd0, snap_ack}, 64'd0);
    check_val("arst_change", {63'd0, change}, 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Enable drop while row 4 is driven, then full restart.
    board = pat1;
    for (int k = 0; k < 60 && r !== 8'h10; k++) cycle(1'b1, 1'b0);
    check_val("wait_r10", {56'd0, r}, 64'h10);
    cycle(1'b0, 1'b0);
    check_val("drop_r", {56'd0, r}, 64'd0);
    n_change = 0;
    first_change = -1;
    cycle(1'b1, 1'b0);
    check_val("restart_r", {56'd0, r}, 64'h01);
    for (int k = 2; k <= 200; k++) begin
      cycle(1'b1, 1'b0);
      if (change && first_change < 0) first_change = k;
    end
    check_val("restart_latency", 64'(first_change), 64'd124);

    // Randomized run against the model.
    pats[0] = 64'd0; pats[1] = PIECE; pats[2] = pat1; pats[3] = {$urandom, $urandom};
    req = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 19) == 0) req = ~req;
      if ($urandom_range(0, 149) == 0) board = pats[$urandom_range(0, 3)];
      if ($urandom_range(0, 399) == 0) board = board ^ (64'd1 << $urandom_range(0, 63));
      cycle(($urandom_range(0, 99) < 98) ? 1'b1 : 1'b0, req);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
